psram_wb_rcache: RTL and testbench

PSRAM_WB_RCACHE -- requirements
Module: psram_wb_rcache

---
 rtl/psram_wb_rcache.sv | 147 ++++++++++++++
 tb/tb_psram_wb_rcache.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_wb_rcache.sv
// Direct-mapped, one-word-per-line read cache between a Wishbone slave port and a PSRAM Wishbone controller.
// Write-hit policy: define PSRAM_WBC_WR_UPDATE_EN to merge write data into the line, else the line is invalidated.
module psram_wb_rcache #(
  parameter int unsigned LINES = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] s_adr_i,
  input  logic [31:0] s_dat_i,
  output logic [31:0] s_dat_o,
  input  logic [3:0]  s_sel_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  output logic        s_ack_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic [3:0]  m_sel_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  input  logic        m_ack_i,
  input  logic        flush_i
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 22 - IW;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

  state_t           state_q, state_d;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];
  logic             abort_q;

  logic [IW-1:0] s_idx, m_idx;
  logic [TW-1:0] s_tag, m_tag;
  logic          s_req, s_hit, m_hit;

  assign s_idx = s_adr_i[2 +: IW];
  assign s_tag = s_adr_i[23 -: TW];
  // The in-flight line is addressed by the registered downstream address.
  assign m_idx = m_adr_o[2 +: IW];
  assign m_tag = m_adr_o[23 -: TW];
  assign s_req = s_cyc_i & s_stb_i;
  assign s_hit = valid_q[s_idx] && (tag_mem[s_idx] == s_tag) && !flush_i;
  assign m_hit = valid_q[m_idx] && (tag_mem[m_idx] == m_tag);

  assign s_ack_o = (state_q == RESP);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (s_req) begin
          if (s_we_i)     state_d = WRITE;
          else if (s_hit) state_d = RESP;
          else            state_d = FILL;
        end
      end
      FILL, WRITE: begin
        if (m_ack_i) state_d = (abort_q || !s_cyc_i) ? IDLE : RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      abort_q <= 1'b0;
      s_dat_o <= '0;
      m_adr_o <= '0;
      m_dat_o <= '0;
      m_sel_o <= '0;
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          abort_q <= 1'b0;
          if (s_req) begin
            if (s_we_i) begin
              m_adr_o <= s_adr_i;
              m_dat_o <= s_dat_i;
              m_sel_o <= s_sel_i;
              m_we_o  <= 1'b1;
              m_cyc_o <= 1'b1;
              m_stb_o <= 1'b1;
            end else if (s_hit) begin
              s_dat_o <= data_mem[s_idx];
            end else begin
              m_adr_o <= {s_adr_i[31:2], 2'b00};
              m_sel_o <= 4'hF;
              m_we_o  <= 1'b0;
              m_cyc_o <= 1'b1;
              m_stb_o <= 1'b1;
            end
          end
        end
        FILL, WRITE: begin
          if (!s_cyc_i) abort_q <= 1'b1;
          if (m_ack_i) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            if (state_q == FILL) begin
              valid_q[m_idx] <= 1'b1;
              s_dat_o        <= m_dat_i;
            end
`ifndef PSRAM_WBC_WR_UPDATE_EN
            else if (m_hit) begin
              valid_q[m_idx] <= 1'b0;
            end
`endif
          end
        end
        default: ;
      endcase
      // Placed last so a coincident flush overrides a fill install.
      if (flush_i) valid_q <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == FILL && m_ack_i) begin
      tag_mem[m_idx]  <= m_tag;
      data_mem[m_idx] <= m_dat_i;
    end
`ifdef PSRAM_WBC_WR_UPDATE_EN
    if (state_q == WRITE && m_ack_i && m_hit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (m_sel_o[b]) data_mem[m_idx][8*b +: 8] <= m_dat_o[8*b +: 8];
      end
    end
`endif
  end

endmodule

// File: tb/tb_psram_wb_rcache.sv
// Directed self-checking bench for psram_wb_rcache with a behavioural PSRAM controller responder.
module tb_psram_wb_rcache;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] s_adr_i, s_dat_i, s_dat_o;
  logic [3:0]  s_sel_i;
  logic        s_cyc_i, s_stb_i, s_we_i, s_ack_o;
  logic [31:0] m_adr_o, m_dat_o, m_dat_i;
  logic [3:0]  m_sel_o;
  logic        m_cyc_o, m_stb_o, m_we_o, m_ack_i;
  logic        flush_i;
  logic        flush_slv = 1'b0;
  logic        flush_main = 1'b0;

  assign flush_i = flush_slv | flush_main;

  psram_wb_rcache #(.LINES(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_sel_i(s_sel_i),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_ack_o(s_ack_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_ack_i(m_ack_i),
    .flush_i(flush_i)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc_cnt = 0;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  int          n_checks = 0;
  int          n_pass = 0;

  // Responder state
  int          mdelay = 20;
  logic [31:0] mrdata = '0;
  int          xfers = 0;
  int          hold_err = 0;
  int          drop_err = 0;
  int unsigned ack_at = 0;
  bit          busy = 1'b0;
  bit          flush_on_ack = 1'b0;
  logic [31:0] l_adr, l_dat;
  logic [3:0]  l_sel;
  logic        l_we;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // PSRAM controller model: acks each strobe after mdelay cycles, checks request stability.
  initial begin
    m_ack_i = 1'b0;
    m_dat_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (m_cyc_o && m_stb_o) begin
        busy = 1'b1;
        xfers++;
        l_adr = m_adr_o; l_dat = m_dat_o; l_sel = m_sel_o; l_we = m_we_o;
        for (int i = 1; i < mdelay; i++) begin
          @(posedge clk_i); #1;
          if (!(m_cyc_o && m_stb_o && m_adr_o === l_adr && m_sel_o === l_sel &&
                m_we_o === l_we && m_dat_o === l_dat)) hold_err++;
        end
        m_ack_i = 1'b1;
        m_dat_i = mrdata;
        ack_at  = cyc_cnt;
        if (flush_on_ack) flush_slv = 1'b1;
        @(posedge clk_i); #1;
        m_ack_i   = 1'b0;
        m_dat_i   = '0;
        flush_slv = 1'b0;
        if (m_cyc_o || m_stb_o) drop_err++;
        busy = 1'b0;
      end
    end
  end

  task automatic wb_read(input logic [31:0] a, input bit fl, output logic [31:0] d,
                         output int unsigned lat, output int unsigned at);
    int unsigned c0;
    @(posedge clk_i); #1;
    c0 = cyc_cnt;
    s_adr_i = a; s_we_i = 1'b0; s_sel_i = 4'hF; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    flush_main = fl;
    d = 'x; at = 0; lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_i); #1;
      flush_main = 1'b0;
      if (s_ack_o) begin
        d = s_dat_o; at = cyc_cnt; lat = cyc_cnt - c0;
        break;
      end
    end
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] dat,
                          output bit acked);
    @(posedge clk_i); #1;
    s_adr_i = a; s_we_i = 1'b1; s_sel_i = sel; s_dat_i = dat; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    acked = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_i); #1;
      if (s_ack_o) begin
        acked = 1'b1;
        break;
      end
    end
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int unsigned lat, at;
    int          x0;
    bit          acked, saw_ack;

    rst_n_i = 1'b0;
    s_adr_i = '0; s_dat_i = '0; s_sel_i = '0; s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_s_ack", {31'd0, s_ack_o}, 32'd0);
    check("rst_s_dat", s_dat_o, 32'd0);
    check("rst_m_cyc", {31'd0, m_cyc_o}, 32'd0);
    check("rst_m_stb", {31'd0, m_stb_o}, 32'd0);
    check("rst_m_we",  {31'd0, m_we_o}, 32'd0);
    check("rst_m_adr", m_adr_o, 32'd0);
    check("rst_m_dat", m_dat_o, 32'd0);
    check("rst_m_sel", {28'd0, m_sel_o}, 32'd0);
    rst_n_i = 1'b1;

    // Cold read miss
    mdelay = 20; mrdata = 32'hDEADBEEF; x0 = xfers;
    wb_read(32'h40, 1'b0, d, lat, at);
    check("cold_data",  d, 32'hDEADBEEF);
    check("cold_xfers", xfers - x0, 32'd1);
    check("cold_adr",   l_adr, 32'h40);
    check("cold_sel",   {28'd0, l_sel}, 32'hF);
    check("cold_we",    {31'd0, l_we}, 32'd0);
    check("cold_ack_t", at, ack_at + 1);

    // Repeat read hit
    x0 = xfers;
    wb_read(32'h40, 1'b0, d, lat, at);
    check("hit_data",  d, 32'hDEADBEEF);
    check("hit_lat",   lat, 32'd1);
    check("hit_xfers", xfers - x0, 32'd0);

    // Conflict on index 0
    mdelay = 4; mrdata = 32'h12345678; x0 = xfers;
    wb_read(32'h60, 1'b0, d, lat, at);
    check("conf_data",  d, 32'h12345678);
    check("conf_xfers", xfers - x0, 32'd1);
    mrdata = 32'hDEADBEEF; x0 = xfers;
    wb_read(32'h40, 1'b0, d, lat, at);
    check("evict_data",  d, 32'hDEADBEEF);
    check("evict_xfers", xfers - x0, 32'd1);
    x0 = xfers;
    wb_read(32'h40, 1'b0, d, lat, at);
    check("rehit_xfers", xfers - x0, 32'd0);

    // Write hit
    x0 = xfers;
    wb_write(32'h42, 4'b0100, 32'h00AB0000, acked);
    check("wr_ack",   {31'd0, acked}, 32'd1);
    check("wr_xfers", xfers - x0, 32'd1);
    check("wr_adr",   l_adr, 32'h42);
    check("wr_we",    {31'd0, l_we}, 32'd1);
    check("wr_sel",   {28'd0, l_sel}, 32'h4);
    check("wr_dat",   l_dat, 32'h00AB0000);
    mrdata = 32'hDEABBEEF; x0 = xfers;
    wb_read(32'h40, 1'b0, d, lat, at);
    check("wrhit_data", d, 32'hDEABBEEF);
`ifdef PSRAM_WBC_WR_UPDATE_EN
    check("wrhit_xfers", xfers - x0, 32'd0);
`else
    check("wrhit_xfers", xfers - x0, 32'd1);
`endif

    // Write miss must not allocate
    wb_write(32'hC4, 4'hF, 32'h55555555, acked);
    check("wrmiss_ack", {31'd0, acked}, 32'd1);
    mrdata = 32'h0C4C4C4C; x0 = xfers;
    wb_read(32'hC4, 1'b0, d, lat, at);
    check("wrmiss_xfers", xfers - x0, 32'd1);
    check("wrmiss_data",  d, 32'h0C4C4C4C);

    // Flush coincident with a read request is a miss
    mrdata = 32'hDEABBEEF; x0 = xfers;
    wb_read(32'h40, 1'b1, d, lat, at);
    check("flreq_xfers", xfers - x0, 32'd1);
    check("flreq_data",  d, 32'hDEABBEEF);
    x0 = xfers;
    wb_read(32'h40, 1'b0, d, lat, at);
    check("flreq_rehit", xfers - x0, 32'd0);

    // Flush coincident with fill ack
    mrdata = 32'h80808080; flush_on_ack = 1'b1; x0 = xfers;
    wb_read(32'h80, 1'b0, d, lat, at);
    flush_on_ack = 1'b0;
    check("flack_data",  d, 32'h80808080);
    check("flack_xfers", xfers - x0, 32'd1);
    x0 = xfers;
    wb_read(32'h80, 1'b0, d, lat, at);
    check("flack_miss", xfers - x0, 32'd1);

    // Upstream abandons a fill
    mdelay = 10; mrdata = 32'hA0A0A0A0; x0 = xfers; saw_ack = 1'b0;
    @(posedge clk_i); #1;
    s_adr_i = 32'hA0; s_we_i = 1'b0; s_sel_i = 4'hF; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (s_ack_o) saw_ack = 1'b1;
    end
    check("abort_busy",  {31'd0, busy}, 32'd0);
    check("abort_noack", {31'd0, saw_ack}, 32'd0);
    check("abort_xfers", xfers - x0, 32'd1);
    x0 = xfers;
    wb_read(32'hA0, 1'b0, d, lat, at);
    check("abort_next_data",  d, 32'hA0A0A0A0);
    check("abort_next_lat",   lat, 32'd1);
    check("abort_next_xfers", xfers - x0, 32'd0);

    check("hold_err", hold_err, 32'd0);
    check("drop_err", drop_err, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
